// File: rtl/dma_stream_merge2to1.sv
// 2-to-1 DMA stream merger: burst-locked arbitration onto one registered output channel.
// Define DMA_MERGE_FIXED_PRIO_EN for fixed channel-0 priority instead of round-robin.
module dma_stream_merge2to1 #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [DATA_WIDTH-1:0] din1,
    input  logic                  din1_valid,
    input  logic                  din1_last,
    output logic                  din1_ready,
    input  logic [DATA_WIDTH-1:0] din2,
    input  logic                  din2_valid,
    input  logic                  din2_last,
    output logic                  din2_ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  dout_last,
    output logic                  dout_sel,
    input  logic                  dout_ready
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e                state_q, state_d;
    logic                  lock_src_q, lock_src_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dout_valid_q, dout_valid_d;
    logic                  dout_last_q, dout_last_d;
    logic                  dout_sel_q, dout_sel_d;

    logic                  load_en;
    logic                  grant_vld;
    logic                  grant_sel;
    logic                  tie_sel;
    logic                  accept;
    logic                  acc_last;
    logic [DATA_WIDTH-1:0] acc_data;

`ifdef DMA_MERGE_FIXED_PRIO_EN
    assign tie_sel = 1'b0;
`else
    logic rr_ptr_q, rr_ptr_d;
    assign tie_sel = rr_ptr_q;
`endif

    always_comb begin
        load_en   = dout_ready | ~dout_valid_q;
        grant_vld = 1'b0;
        grant_sel = 1'b0;
        if (state_q == StLocked) begin
            // Owner keeps the grant even while its valid is low mid-burst.
            grant_vld = 1'b1;
            grant_sel = lock_src_q;
        end else if (din1_valid && din2_valid) begin
            grant_vld = 1'b1;
            grant_sel = tie_sel;
        end else if (din1_valid) begin
            grant_vld = 1'b1;
            grant_sel = 1'b0;
        end else if (din2_valid) begin
            grant_vld = 1'b1;
            grant_sel = 1'b1;
        end
        din1_ready = ARESETn & load_en & grant_vld & ~grant_sel;
        din2_ready = ARESETn & load_en & grant_vld & grant_sel;
        accept     = grant_sel ? (din2_valid & din2_ready) : (din1_valid & din1_ready);
        acc_data   = grant_sel ? din2 : din1;
        acc_last   = grant_sel ? din2_last : din1_last;
    end

    always_comb begin
        state_d      = state_q;
        lock_src_d   = lock_src_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        dout_last_d  = dout_last_q;
        dout_sel_d   = dout_sel_q;
`ifndef DMA_MERGE_FIXED_PRIO_EN
        rr_ptr_d     = rr_ptr_q;
`endif
        if (accept) begin
            dout_d       = acc_data;
            dout_valid_d = 1'b1;
            dout_last_d  = acc_last;
            dout_sel_d   = grant_sel;
            if (acc_last) begin
                state_d = StIdle;
`ifndef DMA_MERGE_FIXED_PRIO_EN
                rr_ptr_d = ~grant_sel;
`endif
            end else begin
                state_d    = StLocked;
                lock_src_d = grant_sel;
            end
        end else if (dout_ready) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q      <= StIdle;
            lock_src_q   <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            dout_sel_q   <= 1'b0;
`ifndef DMA_MERGE_FIXED_PRIO_EN
            rr_ptr_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            lock_src_q   <= lock_src_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            dout_sel_q   <= dout_sel_d;
`ifndef DMA_MERGE_FIXED_PRIO_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign dout_sel   = dout_sel_q;

endmodule
